obj_gfx_shifter: RTL and testbench

Object graphics fetch and pixel shifter, directly upstream of the object line-buffer stage.
- Once per 8-pixel slice, captures the object character address, colour-invert and in-range flags from the object bus.
- Fetches three bitplane bytes from the object graphics ROM over a req/ack handshake.
- Serialises the fetched data as the 3-bit QBUS pixel stream that the line-buffer writer consumes.
- Fetches in slice N are displayed in slice N+1.

---
 rtl/obj_gfx_shifter.sv | 172 +++++++++++++++++
 tb/tb_obj_gfx_shifter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_gfx_shifter.sv
// Object graphics fetch (3 bitplanes over rom_req/rom_ack) and 3-bit QBUS pixel shifter.
// Build option: define OBJ_FETCH_SKIP_EN to skip ROM reads for slices whose INRANG=0.
module obj_gfx_shifter #(
    parameter int CHA_W       = 11,
    parameter int ACK_TIMEOUT = 40
) (
    input  logic             clkm_48MHZ,
    input  logic             RESET,
    input  logic             pix_ce,
    input  logic [2:0]       HN,
    input  logic [CHA_W-1:0] OBJ_CHA,
    input  logic             OBJ_CINV,
    input  logic             INRANG,
    output logic [CHA_W+1:0] rom_addr,
    output logic             rom_req,
    input  logic             rom_ack,
    input  logic [7:0]       rom_data,
    output logic [2:0]       QBUS,
    output logic             busy,
    output logic             overrun
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, FETCH2, DONE} state_t;

    state_t           state_reg;
    state_t           state_adv;
    logic [CNT_W-1:0] tmo_cnt_reg;
    logic             rom_req_reg;
    logic [CHA_W+1:0] rom_addr_reg;
    logic [2:0]       qbus_reg;
    logic             overrun_reg;

    logic [CHA_W-1:0] req_cha_reg;
    logic             req_cinv_reg;
    logic             req_inr_reg;

    logic [2:0][7:0]  st_plane_reg;
    logic             st_cinv_reg;
    logic             st_inr_reg;

    logic [2:0][7:0]  sh_plane_reg;
    logic [2:0][7:0]  sh_plane_next;
    logic             sh_cinv_reg;
    logic             sh_cinv_next;
    logic             sh_inr_reg;
    logic             sh_inr_next;

    logic             slice_start;
    logic             fetching;
    logic             fetch_end;
    logic [1:0]       plane_idx;
    logic [7:0]       fetch_byte;
    logic [2:0]       pix_sel;
    logic [2:0]       pix_bits;

    assign slice_start = pix_ce && (HN == 3'd0);
    assign fetching    = (state_reg == FETCH0) || (state_reg == FETCH1) || (state_reg == FETCH2);
    // A plane ends on ack or when the request has been held ACK_TIMEOUT cycles.
    assign fetch_end   = rom_req_reg && (rom_ack || (tmo_cnt_reg == CNT_W'(ACK_TIMEOUT - 1)));
    assign fetch_byte  = rom_ack ? rom_data : 8'h00;

    always_comb begin
        plane_idx = 2'd0;
        state_adv = DONE;
        case (state_reg)
            FETCH0:  begin plane_idx = 2'd0; state_adv = FETCH1; end
            FETCH1:  begin plane_idx = 2'd1; state_adv = FETCH2; end
            FETCH2:  begin plane_idx = 2'd2; state_adv = DONE;   end
            default: begin plane_idx = 2'd0; state_adv = DONE;   end
        endcase
    end

    // The first pixel of a slice must come from the freshly transferred data.
    always_comb begin
        sh_plane_next = sh_plane_reg;
        sh_cinv_next  = sh_cinv_reg;
        sh_inr_next   = sh_inr_reg;
        if (slice_start) begin
            if (fetching) begin
                sh_plane_next = '0;
                sh_cinv_next  = 1'b0;
                sh_inr_next   = 1'b0;
            end else begin
                sh_plane_next = st_plane_reg;
                sh_cinv_next  = st_cinv_reg;
                sh_inr_next   = st_inr_reg;
            end
        end
    end

    assign pix_sel = sh_cinv_next ? HN : ~HN;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pix
            assign pix_bits[gi] = sh_plane_next[gi][pix_sel];
        end
    endgenerate

    always_ff @(posedge clkm_48MHZ) begin
        if (RESET) begin
            state_reg    <= IDLE;
            tmo_cnt_reg  <= '0;
            rom_req_reg  <= 1'b0;
            rom_addr_reg <= '0;
            qbus_reg     <= 3'd0;
            overrun_reg  <= 1'b0;
            req_cha_reg  <= '0;
            req_cinv_reg <= 1'b0;
            req_inr_reg  <= 1'b0;
            st_plane_reg <= '0;
            st_cinv_reg  <= 1'b0;
            st_inr_reg   <= 1'b0;
            sh_plane_reg <= '0;
            sh_cinv_reg  <= 1'b0;
            sh_inr_reg   <= 1'b0;
        end else begin
            sh_plane_reg <= sh_plane_next;
            sh_cinv_reg  <= sh_cinv_next;
            sh_inr_reg   <= sh_inr_next;
            if (pix_ce) begin
                qbus_reg <= sh_inr_next ? pix_bits : 3'd0;
            end

            if (slice_start) begin
                if (fetching) begin
                    overrun_reg <= 1'b1;
                end
                req_cha_reg  <= OBJ_CHA;
                req_cinv_reg <= OBJ_CINV;
                req_inr_reg  <= INRANG;
                state_reg    <= FETCH0;
                rom_req_reg  <= 1'b0;
                tmo_cnt_reg  <= '0;
            end else if (fetching) begin
`ifdef OBJ_FETCH_SKIP_EN
                if ((state_reg == FETCH0) && !req_inr_reg) begin
                    st_plane_reg <= '0;
                    st_cinv_reg  <= req_cinv_reg;
                    st_inr_reg   <= 1'b0;
                    state_reg    <= DONE;
                end else
`endif
                if (!rom_req_reg) begin
                    // Request is raised one cycle after entering a plane, giving the low gap.
                    rom_req_reg  <= 1'b1;
                    rom_addr_reg <= {plane_idx, req_cha_reg};
                    tmo_cnt_reg  <= '0;
                end else if (fetch_end) begin
                    st_plane_reg[plane_idx] <= fetch_byte;
                    rom_req_reg  <= 1'b0;
                    tmo_cnt_reg  <= '0;
                    state_reg    <= state_adv;
                    if (state_reg == FETCH2) begin
                        st_cinv_reg <= req_cinv_reg;
                        st_inr_reg  <= req_inr_reg;
                    end
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign rom_req  = rom_req_reg;
    assign rom_addr = rom_addr_reg;
    assign QBUS     = qbus_reg;
    assign busy     = fetching;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_obj_gfx_shifter.sv
// Directed bench for obj_gfx_shifter: slice table, timeout, ack/slice collision, reset, overrun.
`timescale 1ns/1ps
module tb_obj_gfx_shifter;

    localparam int CHA_W = 11;

    typedef struct packed {
        logic [CHA_W-1:0] cha;
        logic [7:0]       p0;
        logic [7:0]       p1;
        logic [7:0]       p2;
        logic             cinv;
        logic             inr;
        logic [23:0]      exp;   // octal digit k = QBUS for pixel HN=k
    } row_t;

    logic             clkm_48MHZ = 1'b0;
    logic             RESET;
    logic             pix_ce;
    logic [2:0]       HN;
    logic [CHA_W-1:0] OBJ_CHA;
    logic             OBJ_CINV;
    logic             INRANG;
    logic [CHA_W+1:0] rom_addr;
    logic             rom_req;
    logic             rom_ack;
    logic [7:0]       rom_data;
    logic [2:0]       QBUS;
    logic             busy;
    logic             overrun;

    always #5 clkm_48MHZ = ~clkm_48MHZ;

    obj_gfx_shifter #(.CHA_W(CHA_W), .ACK_TIMEOUT(40)) dut (
        .clkm_48MHZ (clkm_48MHZ),
        .RESET      (RESET),
        .pix_ce     (pix_ce),
        .HN         (HN),
        .OBJ_CHA    (OBJ_CHA),
        .OBJ_CINV   (OBJ_CINV),
        .INRANG     (INRANG),
        .rom_addr   (rom_addr),
        .rom_req    (rom_req),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .QBUS       (QBUS),
        .busy       (busy),
        .overrun    (overrun)
    );

    int               errors = 0;
    int               checks = 0;
    int               lat [3];
    logic [7:0]       rom_bytes [3];
    int               rec_n;
    logic [CHA_W+1:0] rec_addr [8];
    int               rec_len [8];
    int               age;
    logic             prev_req;
    logic [CHA_W+1:0] prev_addr;
    logic [1:0]       rom_pl;
    logic [2:0]       hn_cnt;
    int               sub_cnt;
    row_t             rows [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // ROM model: acks after lat[plane] cycles of rom_req, logs each request.
    initial begin
        rom_ack   = 1'b0;
        rom_data  = 8'h00;
        age       = 0;
        prev_req  = 1'b0;
        prev_addr = '0;
        forever begin
            @(posedge clkm_48MHZ);
            #2;
            if (rom_ack) rom_ack = 1'b0;
            if (rom_req) begin
                if (!prev_req) begin
                    if (rec_n < 8) rec_addr[rec_n] = rom_addr;
                    rec_n++;
                    age = 0;
                end else begin
                    chk("addr_stable", rom_addr, prev_addr);
                end
                if (rec_n >= 1 && rec_n <= 8) rec_len[rec_n-1]++;
                age++;
                rom_pl = rom_addr[CHA_W+1 -: 2];
                if (rom_pl != 2'd3 && age >= lat[rom_pl]) begin
                    rom_ack  = 1'b1;
                    rom_data = rom_bytes[rom_pl];
                    age      = 0;
                end
            end else begin
                age = 0;
            end
            prev_req  = rom_req;
            prev_addr = rom_addr;
        end
    end

    task automatic step();
        @(posedge clkm_48MHZ);
        #1;
        if (pix_ce) hn_cnt = hn_cnt + 3'd1;
        sub_cnt = (sub_cnt + 1) % 8;
        pix_ce  = (sub_cnt == 0);
        HN      = hn_cnt;
    endtask

    task automatic wait_pix(input bit need_hn0);
        for (int n = 0; n < 80; n++) begin
            if (pix_ce && (!need_hn0 || HN == 3'd0)) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL wait_pix: got no pixel enable in 80 cycles, required one");
    endtask

    task automatic set_lat(input int a, input int b, input int c);
        lat[0] = a;
        lat[1] = b;
        lat[2] = c;
    endtask

    // One slice: present r at the slice start, check QBUS against the previous slice's data.
    task automatic run_slice(input string tag, input row_t r, input logic [23:0] exp_prev,
                             input int lat_after);
        logic [2:0] want;
        wait_pix(1'b1);
        OBJ_CHA  = r.cha;
        OBJ_CINV = r.cinv;
        INRANG   = r.inr;
        rom_bytes[0] = r.p0;
        rom_bytes[1] = r.p1;
        rom_bytes[2] = r.p2;
        rec_n = 0;
        for (int k = 0; k < 8; k++) rec_len[k] = 0;
        for (int p = 0; p < 8; p++) begin
            if (p > 0) wait_pix(1'b0);
            step();
            if (p == 0 && lat_after >= 0) set_lat(lat_after, lat_after, lat_after);
            want = exp_prev[3*p +: 3];
            chk($sformatf("%s qbus_px%0d", tag, p), QBUS, want);
        end
        $display("slice %-6s cha=%03h cinv=%0d inr=%0d reqs=%0d busy=%0d overrun=%0d",
                 tag, r.cha, r.cinv, r.inr, rec_n, busy, overrun);
    endtask

    task automatic chk_reqs(input string tag, input row_t r);
        int exp_n = 3;
`ifdef OBJ_FETCH_SKIP_EN
        if (!r.inr) exp_n = 0;
`endif
        chk({tag, " req_count"}, rec_n, exp_n);
        for (int k = 0; k < exp_n && k < 8; k++)
            chk($sformatf("%s addr%0d", tag, k), rec_addr[k], {2'(k), r.cha});
    endtask

    initial begin
        row_t       r_tmo, r_sim, r_after, r_ovr, r_new, r_end;
        logic [23:0] prev;

        rows[0] = '{cha:11'h123, p0:8'h80, p1:8'h00, p2:8'hFF, cinv:1'b0, inr:1'b1, exp:24'o44444445};
        rows[1] = '{cha:11'h456, p0:8'h80, p1:8'hFF, p2:8'hFF, cinv:1'b0, inr:1'b1, exp:24'o66666667};
        rows[2] = '{cha:11'h7FF, p0:8'h80, p1:8'hFF, p2:8'hFF, cinv:1'b1, inr:1'b1, exp:24'o76666666};
        rows[3] = '{cha:11'h000, p0:8'hFF, p1:8'hFF, p2:8'hFF, cinv:1'b0, inr:1'b0, exp:24'o0};
        rows[4] = '{cha:11'h2AA, p0:8'hA5, p1:8'h3C, p2:8'h0F, cinv:1'b0, inr:1'b1, exp:24'o54762301};
        rows[5] = '{cha:11'h555, p0:8'hA5, p1:8'h3C, p2:8'h0F, cinv:1'b1, inr:1'b1, exp:24'o10326745};
        rows[6] = '{cha:11'h001, p0:8'hFF, p1:8'hFF, p2:8'hFF, cinv:1'b1, inr:1'b0, exp:24'o0};
        r_tmo   = '{cha:11'h6C3, p0:8'h80, p1:8'hFF, p2:8'hFF, cinv:1'b0, inr:1'b1, exp:24'o44444445};
        r_sim   = '{cha:11'h0F0, p0:8'hFF, p1:8'hFF, p2:8'hFF, cinv:1'b0, inr:1'b1, exp:24'o0};
        r_after = '{cha:11'h111, p0:8'h80, p1:8'hFF, p2:8'hFF, cinv:1'b0, inr:1'b1, exp:24'o66666667};
        r_ovr   = '{cha:11'h3A5, p0:8'hFF, p1:8'hFF, p2:8'hFF, cinv:1'b0, inr:1'b1, exp:24'o0};
        r_new   = '{cha:11'h15A, p0:8'h80, p1:8'hFF, p2:8'hFF, cinv:1'b0, inr:1'b1, exp:24'o66666667};
        r_end   = '{cha:11'h0AB, p0:8'h00, p1:8'h00, p2:8'h00, cinv:1'b0, inr:1'b1, exp:24'o0};

        RESET    = 1'b1;
        pix_ce   = 1'b0;
        HN       = 3'd0;
        hn_cnt   = 3'd0;
        sub_cnt  = 1;
        OBJ_CHA  = '0;
        OBJ_CINV = 1'b0;
        INRANG   = 1'b0;
        rec_n    = 0;
        set_lat(2, 2, 2);
        for (int k = 0; k < 3; k++) rom_bytes[k] = 8'h00;

        repeat (4) step();
        chk("reset rom_req", rom_req, 0);
        chk("reset rom_addr", rom_addr, 0);
        chk("reset qbus", QBUS, 0);
        chk("reset busy", busy, 0);
        chk("reset overrun", overrun, 0);
        RESET = 1'b0;

        prev = 24'o0;
        for (int s = 0; s < 7; s++) begin
            run_slice($sformatf("row%0d", s), rows[s], prev, -1);
            chk_reqs($sformatf("row%0d", s), rows[s]);
            prev = rows[s].exp;
        end
        chk("table overrun", overrun, 0);

        // Plane 1 never acked: treated as 0x00 after 40 request cycles.
        set_lat(2, 1000, 2);
        run_slice("tmo", r_tmo, prev, -1);
        chk_reqs("tmo", r_tmo);
        chk("tmo plane1_req_cycles", rec_len[1], 40);
        chk("tmo overrun", overrun, 0);

        // Plane 2 ack lands exactly on the next slice start.
        set_lat(20, 20, 21);
        run_slice("tmo_q", r_sim, r_tmo.exp, -1);
        chk_reqs("tmo_q", r_sim);
        chk("sim busy_late", busy, 1);
        chk("sim overrun_before", overrun, 0);
        run_slice("sim_q", r_after, 24'o0, 2);
        chk("sim overrun_after", overrun, 1);
        chk_reqs("sim_q", r_after);

        // Reset while plane 1 is being requested.
        set_lat(2, 30, 2);
        wait_pix(1'b1);
        OBJ_CHA  = 11'h222;
        OBJ_CINV = 1'b0;
        INRANG   = 1'b1;
        step();
        chk("rst pre_qbus_px0", QBUS, 7);
        for (int n = 0; n < 60; n++) begin
            if (rom_req && rom_addr[CHA_W+1 -: 2] == 2'd1) break;
            step();
        end
        chk("rst in_fetch1", int'(rom_req && rom_addr[CHA_W+1 -: 2] == 2'd1), 1);
        RESET = 1'b1;
        step();
        chk("rst rom_req", rom_req, 0);
        chk("rst qbus", QBUS, 0);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun, 0);
        RESET = 1'b0;
        $display("reset mid-fetch applied and released");

        // Slow acks on every plane: fetch still running at the next slice start.
        set_lat(35, 35, 35);
        run_slice("ovr", r_ovr, 24'o0, -1);
        chk("ovr busy_late", busy, 1);
        chk("ovr overrun_before", overrun, 0);
        run_slice("ovr_q", r_new, 24'o0, 2);
        chk("ovr overrun_after", overrun, 1);
        chk_reqs("ovr_q", r_new);
        run_slice("ovr_n", r_end, r_new.exp, -1);
        chk("ovr overrun_sticky", overrun, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
